// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU, store lane alignment, EX/MEM register.
// Latency: 1 clk from ID/EX inputs to mem_* outputs; all outputs registered.
// Backpressure: none; the EX/MEM register loads every cycle (stalls are upstream bubbles).
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic [XLEN-1:0] rs2_data_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [4:0]      rs1_ex,
  input  logic [4:0]      rs2_ex,
  input  logic [4:0]      rd_ex,
  input  logic            alu_src_ex,
  input  logic [2:0]      alu_op_ex,
  input  logic            regwrite_ex,
  input  logic            memread_ex,
  input  logic            memwrite_ex,
  input  logic            memtoreg_ex,
  input  logic [2:0]      loadtype_ex,
  input  logic [2:0]      strtype_ex,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] mem_pc,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [3:0]      mem_be,
  output logic [4:0]      mem_rd,
  output logic            mem_regwrite,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic            mem_memtoreg,
  output logic [2:0]      mem_loadtype,
  output logic            mem_misalign
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;
  logic [XLEN-1:0] st_data;
  logic [3:0]      st_be;
  logic            st_mis;
  logic            ld_mis;
  logic            misalign;

  // EX/MEM holds an ALU result (not load data) that is usable by the next instruction.
  logic exmem_fwd_ok;
  assign exmem_fwd_ok = mem_regwrite && !mem_memtoreg && (mem_rd != 5'd0);

  // Forwarding mux per source: EX/MEM beats WB beats register file.
  always_comb begin
    fwd_rs1 = rs1_data_ex;
    if (exmem_fwd_ok && (mem_rd == rs1_ex)) begin
      fwd_rs1 = mem_alu_result;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1_ex)) begin
      fwd_rs1 = wb_data;
    end
    fwd_rs2 = rs2_data_ex;
    if (exmem_fwd_ok && (mem_rd == rs2_ex)) begin
      fwd_rs2 = mem_alu_result;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2_ex)) begin
      fwd_rs2 = wb_data;
    end
  end

  assign op_b  = alu_src_ex ? imm_ex : fwd_rs2;
  assign shamt = op_b[4:0];

  // ALU: wrap-around arithmetic, logic ops and shifts by opB[4:0].
  always_comb begin
    case (alu_op_ex)
      OP_ADD:  alu_res = fwd_rs1 + op_b;
      OP_SUB:  alu_res = fwd_rs1 - op_b;
      OP_AND:  alu_res = fwd_rs1 & op_b;
      OP_OR:   alu_res = fwd_rs1 | op_b;
      OP_XOR:  alu_res = fwd_rs1 ^ op_b;
      OP_SLL:  alu_res = fwd_rs1 << shamt;
      OP_SRL:  alu_res = fwd_rs1 >> shamt;
      default: alu_res = $unsigned($signed(fwd_rs1) >>> shamt);
    endcase
  end

  // Store lane replication and byte enables; unknown size codes behave as word.
  always_comb begin
    case (strtype_ex)
      3'b000: begin
        st_data = {4{fwd_rs2[7:0]}};
        st_be   = 4'b0001 << alu_res[1:0];
        st_mis  = 1'b0;
      end
      3'b001: begin
        st_data = {2{fwd_rs2[15:0]}};
        st_be   = 4'b0011 << alu_res[1:0];
        st_mis  = alu_res[0];
      end
      default: begin
        st_data = fwd_rs2;
        st_be   = 4'b1111;
        st_mis  = (alu_res[1:0] != 2'b00);
      end
    endcase
  end

  // Load alignment check: byte codes never fault, half needs a[0]=0, others need word alignment.
  always_comb begin
    case (loadtype_ex)
      3'b000, 3'b100: ld_mis = 1'b0;
      3'b001, 3'b101: ld_mis = alu_res[0];
      default:        ld_mis = (alu_res[1:0] != 2'b00);
    endcase
  end

  assign misalign = (memread_ex && ld_mis) || (memwrite_ex && st_mis);

  // EX/MEM register: data always captured, side-effecting controls squashed on misalignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_pc         <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_be         <= 4'b0000;
      mem_rd         <= 5'd0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_memtoreg   <= 1'b0;
      mem_loadtype   <= 3'b000;
      mem_misalign   <= 1'b0;
    end else begin
      mem_pc         <= pc_ex;
      mem_alu_result <= alu_res;
      mem_store_data <= st_data;
      mem_be         <= (memwrite_ex && !misalign) ? st_be : 4'b0000;
      mem_rd         <= rd_ex;
      mem_regwrite   <= regwrite_ex && !misalign;
      mem_memread    <= memread_ex && !misalign;
      mem_memwrite   <= memwrite_ex && !misalign;
      mem_memtoreg   <= memtoreg_ex;
      mem_loadtype   <= loadtype_ex;
      mem_misalign   <= misalign;
    end
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32 pipeline. It consumes the ID/EX register outputs, resolves operand forwarding from the MEM and WB stages, and computes the ALU result. It also aligns store data to byte lanes and captures everything into the EX/MEM pipeline register that feeds the data-memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_ex  in  32  PC of the instruction in EX.
- rs1_data_ex, rs2_data_ex  in  32 each  register-file operands read in ID.
- imm_ex  in  32  sign-extended immediate.
- rs1_ex, rs2_ex, rd_ex  in  5 each  source and destination register indices.
- alu_src_ex  in  1  1 selects imm_ex as operand B; 0 selects forwarded rs2.
- alu_op_ex  in  3  ALU operation code.
- regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex  in  1 each  control bits.
- loadtype_ex, strtype_ex  in  3 each  access size codes.
- wb_regwrite  in  1  WB stage writes the register file.
- wb_rd  in  5  WB destination index.
- wb_data  in  32  WB write-back value.
- mem_pc  out  32  EX/MEM PC.
- mem_alu_result  out  32  EX/MEM ALU result; also the memory address.
- mem_store_data  out  32  lane-aligned store data.
- mem_be  out  4  byte enables; nonzero only for stores.
- mem_rd  out  5  EX/MEM destination index.
- mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg  out  1 each  EX/MEM control bits.
- mem_loadtype  out  3  EX/MEM load size code.
- mem_misalign  out  1  misaligned load or store was squashed in this slot.

## Operation
- **Forwarding, per source (rs1, rs2):**
  - Priority 1, EX/MEM: taken if mem_regwrite && !mem_memtoreg && mem_rd != 0 && mem_rd == rsX_ex. The value is mem_alu_result.
  - Priority 2, WB: taken if wb_regwrite && wb_rd != 0 && wb_rd == rsX_ex. The value is wb_data.
  - Otherwise the register-file data is used.
  - Load-use hazards are handled by upstream bubbles. This block never forwards load data from EX/MEM.
- **Operands:**
  - opA = forwarded rs1.
  - opB = imm_ex if alu_src_ex is 1, else forwarded rs2.
  - Store data always uses forwarded rs2.
- **alu_op_ex codes:**
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLL, 110 SRL, 111 SRA.
  - Shift amount is opB[4:0]. Arithmetic wraps modulo 2^32 with no overflow flag.
- **Store alignment (strtype_ex), with address a = ALU result:**
  - 000 SB: data = {4{rs2[7:0]}}, be = 0001 << a[1:0].
  - 001 SH: data = {2{rs2[15:0]}}, be = 0011 << a[1:0]; legal only when a[0] = 0.
  - 010 SW: data = rs2, be = 1111; legal only when a[1:0] = 00.
  - Any other code with memwrite_ex = 1 is treated as SW.
- **Misalignment:**
  - Loads use the same rules via loadtype_ex: 000/100 byte, 001/101 half, 010 word.
  - A misaligned memread or memwrite squashes the slot. mem_memread, mem_memwrite, mem_regwrite and mem_be are forced to 0, and mem_misalign is set to 1.
- mem_be = 0000 whenever memwrite_ex = 0.
- A bubble from ID/EX (all control bits 0) propagates as a bubble. Data fields are captured regardless.

## Timing
- Forwarding, ALU and alignment logic is combinational within the EX cycle.
- All outputs are registered: latency is 1 clock from ID/EX outputs to mem_* outputs.
- There is no stall input; the EX/MEM register updates every cycle.
- Back-to-back dependent ALU instructions forward EX/MEM with zero bubbles.
- An instruction two ahead forwards from WB.
- When EX/MEM and WB both match the same index, EX/MEM wins.
- Register-file write-through at distance 3 is not this block's concern.
- **Reset:** on a rising clk with rst = 1, every output is 0, including mem_be = 0000 and mem_misalign = 0. rst has priority over all other inputs.
- **Reset mid-stream:** the in-flight instruction is discarded. The first post-reset cycle forwards nothing from EX/MEM, because mem_regwrite is 0.

## Test plan
- **Back-to-back forwarding:** ADD x1=5+7, then SUB x2=x1-x3 with x3=2 (register-file x1 stale at 0) -> mem_alu_result = 12, then 10.
- **Dual-match priority:**
  - Setup: WB has x4=0xAAAA; EX/MEM has x4=0x5555, non-load; next op is OR x5=x4|0.
  - Required: result 0x5555.
  - Repeat with mem_memtoreg=1: result 0xAAAA.
- **x0 never forwards:** mem_rd=0, mem_regwrite=1, mem_alu_result=0xFFFF; next op ADD rs1=x0, rs1_data=0 -> result 0.
- **Store lanes:** SB rs2=0x12345678 at address 0x103 -> mem_be=1000, mem_store_data=0x78787878. SH at 0x102 -> be=1100, data=0x56785678.
- **Misalignment squash:** SW at 0x101, then LH at 0x203 -> both slots have mem_memwrite=0, mem_memread=0, mem_be=0000, mem_misalign=1. The following aligned SW gives be=1111, misalign=0.
- **Reset and shifts:**
  - Assert rst for one cycle mid-stream -> all outputs 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SRL by 33 (opB=0x21) -> shift by 1.
